axis_hdr_strip: RTL and testbench

- Upstream neighbour of the stream byte-realigner. Removes a runtime-configurable number of leading header bytes from each AXI-Stream packet and captures them into a side register.
- Removal is done by clearing tkeep lanes and dropping fully-consumed beats. The first forwarded beat is therefore MS-contiguous (e.g. 8'hF8). The realigner downstream then compacts it.
- Sits between packet ingress and the realigner in the RX datapath.

---
 rtl/axis_pkg.sv | 28 ++
 rtl/axis_skid_buf.sv | 63 ++++++
 rtl/axis_hdr_strip.sv | 106 ++++++++++
 tb/tb_axis_hdr_strip.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared types and byte-lane helpers for the AXI-Stream RX datapath stages.
package axis_pkg;

    typedef enum logic [1:0] {FIRST, STRIP, PASS} state_t;

    localparam int MAX_KW = 64;
    localparam int MAX_DW = MAX_KW * 8;

    // Low r lanes set; callers cast the result down to their own lane count.
    function automatic logic [MAX_KW-1:0] lsb_mask(input int r);
        logic [MAX_KW-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_KW; i++) begin
            if (i < r) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [MAX_DW-1:0] byte_merge(input logic [MAX_DW-1:0] data,
                                                     input logic [MAX_KW-1:0] keep);
        logic [MAX_DW-1:0] o;
        for (int i = 0; i < MAX_KW; i++) begin
            o[i*8 +: 8] = keep[i] ? data[i*8 +: 8] : 8'h00;
        end
        return o;
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-Stream register slice; upstream ready is a flop (skid entry empty).
module axis_skid_buf #(
    parameter int DW = 64,
    parameter int KW = DW / 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [KW-1:0] in_keep,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [KW-1:0] out_keep,
    output logic          out_last
);

    logic          skid_full;
    logic [DW-1:0] skid_data;
    logic [KW-1:0] skid_keep;
    logic          skid_last;
    logic          push;

    assign in_ready = ~skid_full;
    assign push     = in_valid && !skid_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_full <= 1'b0;
            skid_data <= '0;
            skid_keep <= '0;
            skid_last <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else if (!out_valid || out_ready) begin
            if (skid_full) begin
                out_valid <= 1'b1;
                out_data  <= skid_data;
                out_keep  <= skid_keep;
                out_last  <= skid_last;
                skid_full <= 1'b0;
            end else begin
                out_valid <= push;
                if (push) begin
                    out_data <= in_data;
                    out_keep <= in_keep;
                    out_last <= in_last;
                end
            end
        end else if (push) begin
            // Output stalled: park the accepted beat so ready can drop next cycle.
            skid_full <= 1'b1;
            skid_data <= in_data;
            skid_keep <= in_keep;
            skid_last <= in_last;
        end
    end

endmodule

// File: rtl/axis_hdr_strip.sv
// Strips a configurable number of leading header bytes per packet, capturing them in hdr_data.
module axis_hdr_strip
    import axis_pkg::*;
#(
    parameter int AXIS_DW = 64,
    parameter int AXIS_KW = AXIS_DW / 8,
    parameter int HDR_MAX = 16,
    parameter int LEN_W   = $clog2(HDR_MAX + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LEN_W-1:0]     cfg_strip_len,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic [AXIS_DW-1:0]   s_axis_tdata,
    input  logic [AXIS_KW-1:0]   s_axis_tkeep,
    input  logic                 s_axis_tlast,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [AXIS_DW-1:0]   m_axis_tdata,
    output logic [AXIS_KW-1:0]   m_axis_tkeep,
    output logic                 m_axis_tlast,
    output logic [HDR_MAX*8-1:0] hdr_data,
    output logic                 hdr_valid,
    output logic                 hdr_short
);

    state_t             state;
    logic [LEN_W-1:0]   rem;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   cfg_len;
    logic [LEN_W-1:0]   r_cur;
    logic [LEN_W-1:0]   hdr_off;
    logic [LEN_W-1:0]   consumed;
    logic [LEN_W-1:0]   rem_nxt;
    logic               strip_act;
    logic               fwd;
    logic               hs;
    logic [AXIS_KW-1:0] strip_mask;
    logic [AXIS_KW-1:0] fwd_keep;
    logic [AXIS_DW-1:0] fwd_data;

    assign cfg_len = (cfg_strip_len > LEN_W'(HDR_MAX)) ? LEN_W'(HDR_MAX) : cfg_strip_len;
    assign hs      = s_axis_tvalid && s_axis_tready;

    always_comb begin
        r_cur      = (state == FIRST) ? cfg_len : rem;
        hdr_off    = ((state == FIRST) ? cfg_len : len) - r_cur;
        strip_act  = (state != PASS) && (r_cur != '0);
        strip_mask = strip_act ? AXIS_KW'(lsb_mask(int'(r_cur))) : '0;
        // Only lanes actually present count toward the header on a short last beat.
        consumed   = '0;
        for (int i = 0; i < AXIS_KW; i++) begin
            if (strip_mask[i] && s_axis_tkeep[i]) consumed = consumed + LEN_W'(1);
        end
        rem_nxt    = r_cur - consumed;
        fwd_keep   = s_axis_tkeep & ~strip_mask;
        fwd_data   = AXIS_DW'(byte_merge(MAX_DW'(s_axis_tdata), MAX_KW'(~strip_mask)));
        fwd        = (fwd_keep != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FIRST;
            rem       <= '0;
            len       <= '0;
            hdr_data  <= '0;
            hdr_valid <= 1'b0;
            hdr_short <= 1'b0;
        end else begin
            hdr_valid <= 1'b0;
            hdr_short <= 1'b0;
            if (hs) begin
                if (state == FIRST) len <= cfg_len;
                if (strip_act) begin
                    for (int i = 0; i < AXIS_KW; i++) begin
                        if (strip_mask[i] && s_axis_tkeep[i])
                            hdr_data[(int'(hdr_off) + i)*8 +: 8] <= s_axis_tdata[i*8 +: 8];
                    end
                    hdr_valid <= (rem_nxt == '0);
                    hdr_short <= s_axis_tlast && (rem_nxt != '0);
                    rem       <= s_axis_tlast ? '0 : rem_nxt;
                end
                if (s_axis_tlast)                      state <= FIRST;
                else if (strip_act && rem_nxt != '0)   state <= STRIP;
                else                                   state <= PASS;
            end
        end
    end

    axis_skid_buf #(.DW(AXIS_DW), .KW(AXIS_KW)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_axis_tvalid && fwd),
        .in_ready  (s_axis_tready),
        .in_data   (fwd_data),
        .in_keep   (fwd_keep),
        .in_last   (s_axis_tlast),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready),
        .out_data  (m_axis_tdata),
        .out_keep  (m_axis_tkeep),
        .out_last  (m_axis_tlast)
    );

endmodule

// File: tb/tb_axis_hdr_strip.sv
// Scoreboard bench for axis_hdr_strip: byte-level packet model feeds expected beats and header events.
module tb_axis_hdr_strip;

    localparam int DW   = 64;
    localparam int KW   = 8;
    localparam int HMAX = 16;
    localparam int LW   = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [LW-1:0]   cfg_strip_len = '0;
    logic            s_tvalid = 1'b0;
    logic            s_tready;
    logic [DW-1:0]   s_tdata = '0;
    logic [KW-1:0]   s_tkeep = '0;
    logic            s_tlast = 1'b0;
    logic            m_tvalid;
    logic            m_tready = 1'b1;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic            m_tlast;
    logic [HMAX*8-1:0] hdr_data;
    logic            hdr_valid;
    logic            hdr_short;

    always #5 clk = ~clk;

    axis_hdr_strip dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_strip_len (cfg_strip_len),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tlast  (s_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tlast  (m_tlast),
        .hdr_data      (hdr_data),
        .hdr_valid     (hdr_valid),
        .hdr_short     (hdr_short)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    typedef struct {
        logic          is_short;
        logic [127:0]  h;
    } hev_t;

    beat_t expq[$];
    hev_t  hq[$];
    beat_t eb;
    hev_t  eh;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    logic [127:0] hdr_model = '0;

    logic          stalled_prev = 1'b0;
    logic [DW-1:0] prev_d;
    logic [KW-1:0] prev_k;
    logic          prev_l;

    logic tp_on = 1'b0;
    int   tp_n = 0, tp_first = -1, tp_last = -1;
    logic rr_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            stalled_prev = 1'b0;
        end else begin
            if (stalled_prev) begin
                chk("stall_valid", m_tvalid, 1'b1);
                chk("stall_data", m_tdata, prev_d);
                chk("stall_keep", m_tkeep, prev_k);
                chk("stall_last", m_tlast, prev_l);
            end
            if (m_tvalid && m_tready) begin
                chk("beat_expected", expq.size() > 0, 1'b1);
                if (expq.size() > 0) begin
                    eb = expq.pop_front();
                    chk("out_data", m_tdata, eb.d);
                    chk("out_keep", m_tkeep, eb.k);
                    chk("out_last", m_tlast, eb.l);
                end
                if (tp_on) begin
                    if (tp_first < 0) tp_first = cyc;
                    tp_last = cyc;
                    tp_n++;
                end
            end
            if (hdr_valid || hdr_short) begin
                chk("hdr_expected", hq.size() > 0, 1'b1);
                if (hq.size() > 0) begin
                    eh = hq.pop_front();
                    chk("hdr_valid", hdr_valid, !eh.is_short);
                    chk("hdr_short", hdr_short, eh.is_short);
                    chk("hdr_data", hdr_data, eh.h);
                end
            end
            stalled_prev = m_tvalid && !m_tready;
            prev_d = m_tdata;
            prev_k = m_tkeep;
            prev_l = m_tlast;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                             input logic l, input logic [LW-1:0] cfg);
        bit acc;
        int guard;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        cfg_strip_len = cfg;
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 500) begin
            @(negedge clk);
            acc = s_tready;
            tick();
            guard++;
        end
        chk("handshake", acc, 1'b1);
        s_tvalid = 1'b0;
    endtask

    // Byte-level model: byte j of the packet is header iff j < clamp(strip).
    task automatic send_packet(input int nb, input int lanes, input int strip,
                               input int nxt, input int maxgap);
        logic [DW-1:0] d, od;
        logic [KW-1:0] k, ok;
        logic [LW-1:0] cfg;
        int L, total, j;
        bit done;
        beat_t e;
        hev_t  h;
        L     = (strip > HMAX) ? HMAX : strip;
        total = 0;
        done  = 1'b0;
        for (int b = 0; b < nb; b++) begin
            d  = {$urandom, $urandom};
            k  = (b == nb - 1) ? KW'((1 << lanes) - 1) : '1;
            ok = '0;
            od = d;
            for (int i = 0; i < KW; i++) begin
                j = b * KW + i;
                if (j < L) begin
                    od[i*8 +: 8] = 8'h00;
                    if (k[i]) hdr_model[j*8 +: 8] = d[i*8 +: 8];
                end else begin
                    ok[i] = k[i];
                end
                if (k[i]) total++;
            end
            if (ok != '0) begin
                e.d = od; e.k = ok; e.l = (b == nb - 1);
                expq.push_back(e);
            end
            if (L > 0 && !done && total >= L) begin
                h.is_short = 1'b0; h.h = hdr_model;
                hq.push_back(h);
                done = 1'b1;
            end
            if (L > 0 && !done && b == nb - 1) begin
                h.is_short = 1'b1; h.h = hdr_model;
                hq.push_back(h);
            end
            if (b == 0)           cfg = LW'(strip);
            else if (b == nb - 1) cfg = LW'(nxt);
            else                  cfg = LW'($urandom_range(0, 31));
            send_beat(d, k, (b == nb - 1), cfg);
            if (maxgap > 0) repeat ($urandom_range(0, maxgap)) tick();
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        m_tready = 1'b1;
        while ((expq.size() > 0 || hq.size() > 0) && g < 1000) begin
            tick();
            g++;
        end
        repeat (4) tick();
        chk("drain_beats", expq.size(), 0);
        chk("drain_hdr", hq.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st[31];
        repeat (3) tick();
        @(negedge clk);
        chk("rst_m_tvalid", m_tvalid, 1'b0);
        chk("rst_s_tready", s_tready, 1'b1);
        chk("rst_m_tdata", m_tdata, '0);
        chk("rst_m_tkeep", m_tkeep, '0);
        chk("rst_m_tlast", m_tlast, 1'b0);
        chk("rst_hdr_data", hdr_data, '0);
        chk("rst_hdr_valid", hdr_valid, 1'b0);
        chk("rst_hdr_short", hdr_short, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        send_packet(3, 4, 0, 0, 0);   drain();
        send_packet(3, 4, 3, 3, 0);   drain();
        send_packet(3, 8, 10, 10, 0); drain();
        send_packet(2, 8, 16, 8, 0);
        send_packet(1, 6, 8, 8, 0);   drain();
        send_packet(3, 5, 20, 0, 0);  drain();

        // Back-to-back packets, next length presented on each tlast beat, random backpressure.
        for (int i = 0; i < 31; i++) st[i] = $urandom_range(0, 20);
        rr_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 30; i++)
                    send_packet($urandom_range(1, 5), $urandom_range(1, 8), st[i], st[i+1],
                                (i % 3 == 0) ? 2 : 0);
                rr_on = 1'b0;
            end
            begin
                while (rr_on) begin
                    tick();
                    m_tready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain();

        tp_on = 1'b1;
        send_packet(6, 8, 0, 0, 0);
        drain();
        tp_on = 1'b0;
        chk("tp_beats", tp_n, 6);
        chk("tp_span", tp_last - tp_first, 5);

        // Fill both slice entries, then reset mid-packet.
        m_tready = 1'b0;
        send_beat({$urandom, $urandom}, '1, 1'b0, '0);
        send_beat({$urandom, $urandom}, '1, 1'b0, '0);
        @(negedge clk);
        chk("skid_full_tready", s_tready, 1'b0);
        chk("skid_full_valid", m_tvalid, 1'b1);
        tick();
        rst = 1'b1;
        expq.delete();
        hq.delete();
        hdr_model = '0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_m_tvalid", m_tvalid, 1'b0);
        chk("mrst_s_tready", s_tready, 1'b1);
        chk("mrst_m_tdata", m_tdata, '0);
        chk("mrst_m_tkeep", m_tkeep, '0);
        chk("mrst_m_tlast", m_tlast, 1'b0);
        chk("mrst_hdr_data", hdr_data, '0);
        chk("mrst_hdr_valid", hdr_valid, 1'b0);
        chk("mrst_hdr_short", hdr_short, 1'b0);
        tick();
        m_tready = 1'b1;
        send_packet(3, 7, 5, 5, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
